// File: rtl/lora_tx_pkg.sv
// Shared definitions for the LoRa TX clock-domain control blocks.
//   seq_state_t : state encoding of the lock-qualified release sequencer
//   LOSS_CNT_W  : width of the saturating lock-loss counter
//   sat_inc     : saturating increment for LOSS_CNT_W-wide counters
package lora_tx_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchroniser for a single asynchronous status bit (PLL lock
// and similar). All flops reset to 0, so the synchronised output reads
// "not locked" until the input has been seen for SYNC_STAGES edges.
//   clk    : destination clock
//   rst    : asynchronous active-high reset
//   d_i    : asynchronous input bit
//   q_o    : synchronised output, SYNC_STAGES edges behind d_i
module lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/lock_release_seq.sv
// Lock-qualified reset-release sequencer. Waits for synchronised PLL lock to
// be stable for SETTLE_CYCLES, then releases NUM_STAGES domains one per
// STAGE_GAP cycles. Any loss of lock after WAIT_LOCK restarts the sequence.
//   clk         : single clock
//   rst         : asynchronous active-high reset
//   clkLock     : raw PLL lock, asynchronous to clk
//   stageDone   : per-domain release, set in ascending order, cleared together
//   allDone     : every stageDone bit set
//   lockLost    : one-cycle pulse on lock loss outside WAIT_LOCK
//   lockTimeout : no lock for TIMEOUT_CYCLES while in WAIT_LOCK
//   lossCount   : saturating count of lock losses
//
// state        | meaning
// WAIT_LOCK    | all stages held, timeout counter running
// SETTLE       | lock seen, counting stable cycles before stage 0
// RELEASE      | releasing stages 1..NUM_STAGES-1 every STAGE_GAP cycles
// RUN          | all stages released, holding
module lock_release_seq
  import lora_tx_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int SETTLE_CYCLES  = 51,
  parameter int STAGE_GAP      = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 20,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clkLock,
  output logic [NUM_STAGES-1:0] stageDone,
  output logic                  allDone,
  output logic                  lockLost,
  output logic                  lockTimeout,
  output logic [LOSS_CNT_W-1:0] lossCount
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TOUT        = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TOUT_M1     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_STAGES - 1);

  logic lock_s;

  seq_state_t            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      tcnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_STAGES-1:0] stageDone_q;
  logic                  allDone_q;
  logic                  lockLost_q;
  logic                  lockTimeout_q;
  logic [LOSS_CNT_W-1:0] lossCount_q;

  lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (clkLock),
    .q_o (lock_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_WAIT_LOCK;
      cnt_q         <= '0;
      tcnt_q        <= '0;
      idx_q         <= IDX_FIRST;
      stageDone_q   <= '0;
      allDone_q     <= 1'b0;
      lockLost_q    <= 1'b0;
      lockTimeout_q <= 1'b0;
      lossCount_q   <= '0;
    end else begin
      lockLost_q <= 1'b0;
      if (state_q != ST_WAIT_LOCK && !lock_s) begin
        // Loss wins over any release due on this edge.
        state_q     <= ST_WAIT_LOCK;
        stageDone_q <= '0;
        allDone_q   <= 1'b0;
        cnt_q       <= '0;
        tcnt_q      <= '0;
        idx_q       <= IDX_FIRST;
        lockLost_q  <= 1'b1;
        lossCount_q <= sat_inc(lossCount_q);
      end else begin
        case (state_q)
          ST_WAIT_LOCK: begin
            stageDone_q <= '0;
            allDone_q   <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= IDX_FIRST;
            if (lock_s) begin
              state_q       <= ST_SETTLE;
              tcnt_q        <= '0;
              lockTimeout_q <= 1'b0;
            end else begin
              if (tcnt_q != TOUT) begin
                tcnt_q <= tcnt_q + 1'b1;
              end
              // Registered flag tracks the value tcnt takes on this edge.
              lockTimeout_q <= (tcnt_q >= TOUT_M1);
            end
          end
          ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              stageDone_q[0] <= 1'b1;
              cnt_q          <= '0;
              idx_q          <= IDX_FIRST;
              if (NUM_STAGES == 1) begin
                state_q   <= ST_RUN;
                allDone_q <= 1'b1;
              end else begin
                state_q <= ST_RELEASE;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_RELEASE: begin
            if (cnt_q == GAP_LAST) begin
              stageDone_q[idx_q] <= 1'b1;
              cnt_q              <= '0;
              if (idx_q == IDX_LAST) begin
                state_q   <= ST_RUN;
                allDone_q <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_RUN: begin
            state_q <= ST_RUN;
          end
          default: begin
            state_q <= ST_WAIT_LOCK;
          end
        endcase
      end
    end
  end

  assign stageDone   = stageDone_q;
  assign allDone     = allDone_q;
  assign lockLost    = lockLost_q;
  assign lockTimeout = lockTimeout_q;
  assign lossCount   = lossCount_q;

endmodule

// File: tb/tb_lock_release_seq.sv
module tb_lock_release_seq;

  logic       clk;
  logic       rst, rst_t;
  logic       clkLock, lock_t;
  logic [3:0] stageDone, stageDone_t;
  logic       allDone, allDone_t;
  logic       lockLost, lockLost_t;
  logic       lockTimeout, lockTimeout_t;
  logic [7:0] lossCount, lossCount_t;

  int total = 0;
  int bad   = 0;
  int cur_edge;

  lock_release_seq dut (
    .clk         (clk),
    .rst         (rst),
    .clkLock     (clkLock),
    .stageDone   (stageDone),
    .allDone     (allDone),
    .lockLost    (lockLost),
    .lockTimeout (lockTimeout),
    .lossCount   (lossCount)
  );

  lock_release_seq #(
    .TIMEOUT_CYCLES(100)
  ) dut_t (
    .clk         (clk),
    .rst         (rst_t),
    .clkLock     (lock_t),
    .stageDone   (stageDone_t),
    .allDone     (allDone_t),
    .lockLost    (lockLost_t),
    .lockTimeout (lockTimeout_t),
    .lossCount   (lossCount_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to edge n and sample 1 time unit after it.
  task automatic step_to(input int n);
    while (cur_edge < n) begin
      @(posedge clk);
      cur_edge++;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rst_t = 1'b1; clkLock = 1'b0; lock_t = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rst_t = 1'b0;
    cur_edge = -1;
  endtask

  initial begin
    rst = 1'b1; rst_t = 1'b1; clkLock = 1'b0; lock_t = 1'b0;
    cur_edge = -1;

    // Reset values
    do_reset();
    chk("rst_stage", 32'(stageDone), 32'h0);
    chk("rst_all", 32'(allDone), 32'h0);
    chk("rst_lost", 32'(lockLost), 32'h0);
    chk("rst_tout", 32'(lockTimeout), 32'h0);
    chk("rst_loss", 32'(lossCount), 32'h0);

    // 1: lock held from edge 0
    clkLock = 1'b1;
    step_to(52);  chk("s1_e52", 32'(stageDone), 32'h0);
    step_to(53);  chk("s1_e53", 32'(stageDone), 32'h1);
    step_to(68);  chk("s1_e68", 32'(stageDone), 32'h1);
    step_to(69);  chk("s1_e69", 32'(stageDone), 32'h3);
    step_to(85);  chk("s1_e85", 32'(stageDone), 32'h7);
    step_to(100); chk("s1_e100", 32'(stageDone), 32'h7);
                  chk("s1_all100", 32'(allDone), 32'h0);
    step_to(101); chk("s1_e101", 32'(stageDone), 32'hF);
                  chk("s1_all101", 32'(allDone), 32'h1);
                  chk("s1_loss", 32'(lossCount), 32'h0);
    step_to(140); chk("s1_hold", 32'(stageDone), 32'hF);
                  chk("s1_nolost", 32'(lockLost), 32'h0);

    // 2: drop after edge 90, response at 93, then full re-sequence
    do_reset();
    clkLock = 1'b1;
    step_to(90);  chk("s2_e90", 32'(stageDone), 32'h7);
    clkLock = 1'b0;
    step_to(92);  chk("s2_e92", 32'(stageDone), 32'h7);
                  chk("s2_lost92", 32'(lockLost), 32'h0);
    step_to(93);  chk("s2_e93", 32'(stageDone), 32'h0);
                  chk("s2_lost93", 32'(lockLost), 32'h1);
                  chk("s2_loss93", 32'(lossCount), 32'h1);
    step_to(94);  chk("s2_lost94", 32'(lockLost), 32'h0);
    clkLock = 1'b1;
    step_to(147); chk("s2_e147", 32'(stageDone), 32'h0);
    step_to(148); chk("s2_e148", 32'(stageDone), 32'h1);
    step_to(196); chk("s2_e196", 32'(stageDone), 32'hF);
                  chk("s2_all196", 32'(allDone), 32'h1);
                  chk("s2_loss196", 32'(lossCount), 32'h1);

    // 3: 30 on / 10 off, never settles
    do_reset();
    clkLock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_to(k * 40 + 29);
      chk("s3_stage", 32'(stageDone), 32'h0);
      clkLock = 1'b0;
      step_to(k * 40 + 32);
      chk("s3_lost", 32'(lockLost), 32'h1);
      chk("s3_loss", 32'(lossCount), 32'(k + 1));
      step_to(k * 40 + 39);
      clkLock = 1'b1;
    end
    step_to(160); chk("s3_end", 32'(stageDone), 32'h0);

    // 4: timeout of 100 cycles; first edge after reset is edge 1
    do_reset();
    cur_edge = 0;
    step_to(99);  chk("s4_e99", 32'(lockTimeout_t), 32'h0);
    step_to(100); chk("s4_e100", 32'(lockTimeout_t), 32'h1);
    step_to(150); chk("s4_e150", 32'(lockTimeout_t), 32'h1);
                  chk("s4_main", 32'(lockTimeout), 32'h0);
    lock_t = 1'b1;
    step_to(152); chk("s4_e152", 32'(lockTimeout_t), 32'h1);
    step_to(153); chk("s4_e153", 32'(lockTimeout_t), 32'h0);
    step_to(160); chk("s4_e160", 32'(lockTimeout_t), 32'h0);

    // 5: 300 losses saturate at 255
    do_reset();
    for (int i = 0; i < 300; i++) begin
      clkLock = 1'b1;
      step_to(i * 10 + 4);
      clkLock = 1'b0;
      step_to(i * 10 + 7);
      if (i == 253) chk("s5_254", 32'(lossCount), 32'd254);
      if (i == 254) chk("s5_255", 32'(lossCount), 32'd255);
      if (i == 299) chk("s5_lost", 32'(lockLost), 32'h1);
      step_to(i * 10 + 9);
    end
    step_to(3005);
    chk("s5_sat", 32'(lossCount), 32'd255);
    chk("s5_stage", 32'(stageDone), 32'h0);

    // 6: async reset mid-RELEASE
    do_reset();
    clkLock = 1'b1;
    step_to(75);  chk("s6_e75", 32'(stageDone), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_stage", 32'(stageDone), 32'h0);
    chk("s6_all", 32'(allDone), 32'h0);
    chk("s6_lost", 32'(lockLost), 32'h0);
    chk("s6_tout", 32'(lockTimeout), 32'h0);
    chk("s6_loss", 32'(lossCount), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
